// File: rtl/apu_length_bank_pkg.sv
// apu_length_bank_pkg: shared length table, index type and channel numbering for the APU length bank
package apu_pkg;
   typedef logic [4:0] len_idx_t;
   localparam logic [7:0] LENGTH_LUT [0:31] = '{
      8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
   };
   localparam int CH_PULSE1 = 0;
   localparam int CH_PULSE2 = 1;
   localparam int CH_TRI    = 2;
   localparam int CH_NOISE  = 3;
endpackage

// File: rtl/apu_length_bank_chan.sv
// apu_length_chan: one length counter with registered halt and the write/clock ordering quirks
module apu_length_chan
   import apu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_halfframe,
   input  logic     i_en,
   input  logic     i_halt,
   input  logic     i_load,
   input  len_idx_t i_len_idx,
   output logic     o_active,
   output logic     o_halt_q
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_halt_q;
   logic             w_dec;
   // a decrement wins over a coincident reload; disable beats everything
   always_comb begin
      w_dec     = i_halfframe && (r_cnt != '0) && !r_halt_q;
      w_cnt_nxt = !i_en ? '0 : (i_load && !w_dec) ? CNT_W'(LENGTH_LUT[i_len_idx]) : w_dec ? r_cnt - CNT_W'(1) : r_cnt;
   end
   // counter and one-cycle-delayed halt
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_halt_q <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_halt_q <= i_halt;
      end
   end
   assign o_active = r_cnt != '0;
   assign o_halt_q = r_halt_q;
endmodule

// File: rtl/apu_length_bank.sv
// apu_length_bank: per-channel NES APU length counters; APU_LENGTH_LINEAR_EN adds the triangle linear counter
module apu_length_bank
   import apu_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int CNT_W  = 8,
   parameter int LIN_CH = CH_TRI
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halfframe,
   input  logic             quarterframe,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   halt,
   input  logic [NCH-1:0]   load,
   input  logic [5*NCH-1:0] len_idx,
   input  logic [6:0]       lin_reload_val,
   input  logic             lin_load,
   output logic [NCH-1:0]   active
);
   logic [NCH-1:0] w_len_act;
   logic [NCH-1:0] w_halt_q;
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      apu_length_chan #(.CNT_W(CNT_W)) u_chan (
         .clk         (clk),
         .rst         (rst),
         .i_halfframe (halfframe),
         .i_en        (en[i]),
         .i_halt      (halt[i]),
         .i_load      (load[i]),
         .i_len_idx   (len_idx_t'(len_idx[5*i +: 5])),
         .o_active    (w_len_act[i]),
         .o_halt_q    (w_halt_q[i])
      );
   end
`ifdef APU_LENGTH_LINEAR_EN
   logic [6:0] r_lin;
   logic       r_lin_rf;
   logic       w_rf;
   assign w_rf = r_lin_rf | lin_load;
   // linear counter: reload or count down on quarter-frame; flag survives while control/halt is held
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lin    <= '0;
         r_lin_rf <= 1'b0;
      end else if (quarterframe) begin
         r_lin    <= w_rf ? lin_reload_val : (r_lin != '0) ? r_lin - 7'd1 : r_lin;
         r_lin_rf <= lin_load | (w_rf & w_halt_q[LIN_CH]);
      end else if (lin_load) begin
         r_lin_rf <= 1'b1;
      end
   end
   // gate the linear channel's flag with its linear counter
   always_comb begin
      active         = w_len_act;
      active[LIN_CH] = w_len_act[LIN_CH] && (r_lin != '0);
   end
`else
   logic w_unused;
   assign w_unused = ^{quarterframe, lin_load, lin_reload_val, w_halt_q, 1'(LIN_CH)};
   assign active   = w_len_act;
`endif
endmodule

// File: tb/tb_apu_length_bank.sv
// tb_apu_length_bank: directed plus randomized checks of apu_length_bank against a behavioural model
module tb_apu_length_bank;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halfframe = 1'b0;
   logic        quarterframe = 1'b0;
   logic        lin_load = 1'b0;
   logic [3:0]  en = '0;
   logic [3:0]  halt = '0;
   logic [3:0]  load = '0;
   logic [19:0] len_idx = '0;
   logic [6:0]  lin_reload_val = '0;
   logic [3:0]  active;
   int checks = 0;
   int failures = 0;
   int lut [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
   int m_cnt [4];
   int m_hq [4];
   int m_lin = 0;
   int m_rf = 0;
   always #5 clk = ~clk;
   apu_length_bank u_dut (
      .clk            (clk),
      .rst            (rst),
      .halfframe      (halfframe),
      .quarterframe   (quarterframe),
      .en             (en),
      .halt           (halt),
      .load           (load),
      .len_idx        (len_idx),
      .lin_reload_val (lin_reload_val),
      .lin_load       (lin_load),
      .active         (active)
   );
   logic [7:0] d_cnt [4];
   logic [3:0] d_hq;
   assign d_cnt[0] = u_dut.g_ch[0].u_chan.r_cnt;
   assign d_cnt[1] = u_dut.g_ch[1].u_chan.r_cnt;
   assign d_cnt[2] = u_dut.g_ch[2].u_chan.r_cnt;
   assign d_cnt[3] = u_dut.g_ch[3].u_chan.r_cnt;
   assign d_hq[0]  = u_dut.g_ch[0].u_chan.r_halt_q;
   assign d_hq[1]  = u_dut.g_ch[1].u_chan.r_halt_q;
   assign d_hq[2]  = u_dut.g_ch[2].u_chan.r_halt_q;
   assign d_hq[3]  = u_dut.g_ch[3].u_chan.r_halt_q;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      int n_cnt [4];
      int n_hq [4];
      int n_lin;
      int n_rf;
      int rfe;
      for (int i = 0; i < 4; i++) begin
         int c = m_cnt[i];
         int v = lut[len_idx[5*i +: 5]];
         bit can_dec = (c != 0) && (m_hq[i] == 0);
         if (rst) n_cnt[i] = 0;
         else if (!en[i]) n_cnt[i] = 0;
         else if (load[i] && halfframe) n_cnt[i] = can_dec ? c - 1 : v;
         else if (load[i]) n_cnt[i] = v;
         else if (halfframe && can_dec) n_cnt[i] = c - 1;
         else n_cnt[i] = c;
         n_hq[i] = rst ? 0 : int'(halt[i]);
      end
      n_lin = m_lin;
      n_rf = m_rf;
      if (rst) begin
         n_lin = 0;
         n_rf = 0;
      end else if (quarterframe) begin
         rfe = m_rf | int'(lin_load);
         n_lin = rfe ? int'(lin_reload_val) : (m_lin > 0 ? m_lin - 1 : 0);
         n_rf = (lin_load || (rfe && m_hq[2] != 0)) ? 1 : 0;
      end else if (lin_load) n_rf = 1;
      @(posedge clk);
      #1;
      m_cnt = n_cnt;
      m_hq = n_hq;
      m_lin = n_lin;
      m_rf = n_rf;
      for (int i = 0; i < 4; i++) begin
         bit exp_act = m_cnt[i] != 0;
`ifdef APU_LENGTH_LINEAR_EN
         if (i == 2) exp_act = exp_act && (m_lin != 0);
`endif
         chk($sformatf("cnt%0d", i), d_cnt[i], m_cnt[i]);
         chk($sformatf("act%0d", i), active[i], exp_act);
         chk($sformatf("hq%0d", i), d_hq[i], m_hq[i]);
      end
`ifdef APU_LENGTH_LINEAR_EN
      chk("lin", u_dut.r_lin, m_lin);
`endif
   endtask
   initial begin
      foreach (m_cnt[i]) begin
         m_cnt[i] = 0;
         m_hq[i] = 0;
      end
      cyc();
      chk("reset_active", active, 0);
      rst = 1'b0;
      en = 4'hF;
      load = 4'b0001; len_idx[4:0] = 5'd3; cyc(); load = '0;
      chk("load_visible", active[0], 1);
      halfframe = 1'b1; cyc();
      chk("first_strobe", d_cnt[0], 1);
      chk("first_strobe_act", active[0], 1);
      cyc();
      chk("second_strobe_act", active[0], 0);
      cyc();
      chk("no_wrap", d_cnt[0], 0);
      halfframe = 1'b0;
      load = 4'b0001; len_idx[4:0] = 5'd7; cyc(); load = '0;
      halfframe = 1'b1; cyc(); halfframe = 1'b0;
      chk("cnt_five", d_cnt[0], 5);
      load = 4'b0001; len_idx[4:0] = 5'd1; halfframe = 1'b1; cyc(); load = '0;
      chk("reload_dropped", d_cnt[0], 4);
      for (int k = 0; k < 4; k++) cyc();
      load = 4'b0001; cyc(); load = '0; halfframe = 1'b0;
      chk("reload_at_zero", d_cnt[0], 254);
      load = 4'b0001; len_idx[4:0] = 5'd0; cyc(); load = '0;
      halt[0] = 1'b1; halfframe = 1'b1; cyc();
      chk("halt_late", d_cnt[0], 9);
      cyc();
      chk("halt_holds", d_cnt[0], 9);
      halt[0] = 1'b0; halfframe = 1'b0; cyc();
      load = 4'b0001; len_idx[4:0] = 5'd8; cyc(); load = '0;
      chk("cnt_160", d_cnt[0], 160);
      en[0] = 1'b0; cyc();
      chk("disable_clears", d_cnt[0], 0);
      load = 4'b0001; cyc(); load = '0;
      chk("disabled_load", active[0], 0);
      en = 4'hF;
      load = 4'hF; len_idx = 20'($urandom); cyc(); load = '0;
      halt = 4'hF; cyc();
      rst = 1'b1; halfframe = 1'b1; load = 4'hF; cyc();
      chk("rst_active", active, 0);
      chk("rst_halt_q", d_hq, 0);
      rst = 1'b0; halfframe = 1'b0; load = '0; halt = '0; cyc();
`ifdef APU_LENGTH_LINEAR_EN
      load = 4'b0100; len_idx[14:10] = 5'd2; cyc(); load = '0;
      lin_reload_val = 7'd3; lin_load = 1'b1; cyc(); lin_load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         quarterframe = 1'b1; cyc(); quarterframe = 1'b0;
         chk("lin_seq", u_dut.r_lin, 3 - k);
      end
      chk("lin_active_fall", active[2], 0);
      halt[2] = 1'b1; cyc();
      lin_load = 1'b1; cyc(); lin_load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         quarterframe = 1'b1; cyc(); quarterframe = 1'b0;
         chk("lin_halt_act", active[2], 1);
      end
      halt = '0; cyc();
`endif
      for (int k = 0; k < 500; k++) begin
         rst = $urandom_range(0, 99) == 0;
         en = {$urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0};
         if ($urandom_range(0, 9) == 0) halt = 4'($urandom);
         load = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
         len_idx = 20'($urandom);
         halfframe = $urandom_range(0, 3) == 0;
         quarterframe = $urandom_range(0, 3) == 0;
         lin_load = $urandom_range(0, 7) == 0;
         lin_reload_val = 7'($urandom);
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
